// File: rtl/munoc_rr_gather_pkg.sv
// munoc_rr_gather_pkg: shared constants and helpers for the round-robin gather
package munoc_rr_gather_pkg;
   localparam int MAX_PORT = 64;
   localparam logic [MAX_PORT-1:0] PTR_RESET = MAX_PORT'(1);
   function automatic int slice_width(input int bw, input int n);
      return bw * n;
   endfunction
endpackage

// File: rtl/munoc_rr_gather_fifo.sv
// ervp_small_fifo: small synchronous FIFO with pop-through write acceptance
// Ports: clk, rstnn (async active-low), enable, clear,
//        wready/wrequest/wdata (push side), rready/rrequest/rdata (pop side, rdata = head)
module ervp_small_fifo import munoc_rr_gather_pkg::*; #(
   parameter int BW_DATA = 1,
   parameter int DEPTH = 1
)(
   input  logic               clk,
   input  logic               rstnn,
   input  logic               enable,
   input  logic               clear,
   output logic               wready,
   input  logic               wrequest,
   input  logic [BW_DATA-1:0] wdata,
   output logic               rready,
   input  logic               rrequest,
   output logic [BW_DATA-1:0] rdata
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [BW_DATA-1:0] mem [2**AW];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic push, pop;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign rready = cnt != '0;
   assign pop = enable & rrequest & rready;
   // a full FIFO still accepts a push when its head leaves in the same cycle
   assign wready = enable & ((cnt != CW'(DEPTH)) | pop);
   assign push = wrequest & wready;
   assign rdata = mem[rp];
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         for (int k = 0; k < 2**AW; k++) mem[k] <= '0;
      end else if (clear) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         if (push) mem[wp] <= wdata;
         if (push) wp <= nxt(wp);
         if (pop) rp <= nxt(rp);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/munoc_rr_gather.sv
// munoc_rr_gather: strict round-robin merge of NUM_PORT FIFO-buffered streams into one
// Ports: clk, rstnn (async active-low), init (sync pointer return to port 0),
//        wready/wrequest/wdata (per-port push, port i at wdata[BW_DATA*(i+1)-1 -: BW_DATA]),
//        rready/rrequest/rdata/rindex (merged output, rindex one-hot source port)
// Macro MUNOC_RR_GATHER_OUTREG_EN adds a 1-entry output register stage.
module munoc_rr_gather import munoc_rr_gather_pkg::*; #(
   parameter int BW_DATA = 1,
   parameter int NUM_PORT = 1,
   parameter int DEPTH = 1
)(
   input  logic                                          clk,
   input  logic                                          rstnn,
   input  logic                                          init,
   output logic [NUM_PORT-1:0]                           wready,
   input  logic [NUM_PORT-1:0]                           wrequest,
   input  logic [slice_width(BW_DATA, NUM_PORT)-1:0]     wdata,
   output logic                                          rready,
   input  logic                                          rrequest,
   output logic [BW_DATA-1:0]                            rdata,
   output logic [NUM_PORT-1:0]                           rindex
);
   localparam logic [NUM_PORT-1:0] PTR_INIT = PTR_RESET[NUM_PORT-1:0];
   logic [NUM_PORT-1:0] ptr, ptr_nxt, fifo_rready, fifo_pop;
   logic [BW_DATA-1:0] head [NUM_PORT];
   logic [BW_DATA-1:0] sel_data;
   logic sel_ready, take;
   for (genvar i = 0; i < NUM_PORT; i++) begin : g_port
      ervp_small_fifo #(.BW_DATA(BW_DATA), .DEPTH(DEPTH)) u_fifo (
         .clk(clk),
         .rstnn(rstnn),
         .enable(1'b1),
         .clear(1'b0),
         .wready(wready[i]),
         .wrequest(wrequest[i]),
         .wdata(wdata[BW_DATA*(i+1)-1 -: BW_DATA]),
         .rready(fifo_rready[i]),
         .rrequest(fifo_pop[i]),
         .rdata(head[i])
      );
   end
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_PORT; k++) sel_data = sel_data | (ptr[k] ? head[k] : '0);
   end
   assign sel_ready = |(ptr & fifo_rready);
   assign fifo_pop = ptr & {NUM_PORT{take}};
   // rotate left by one; collapses to ptr itself when NUM_PORT is 1
   assign ptr_nxt = (ptr << 1) | (ptr >> (NUM_PORT - 1));
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) ptr <= PTR_INIT;
      else if (init) ptr <= PTR_INIT;
      else if (take) ptr <= ptr_nxt;
   end
`ifdef MUNOC_RR_GATHER_OUTREG_EN
   logic ov;
   logic [BW_DATA-1:0] od;
   logic [NUM_PORT-1:0] oi;
   // refill whenever the register is empty or drained this cycle
   assign take = sel_ready & (~ov | rrequest);
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         ov <= 1'b0;
         od <= '0;
         oi <= PTR_INIT;
      end else if (take) begin
         ov <= 1'b1;
         od <= sel_data;
         oi <= ptr;
      end else if (rrequest) begin
         ov <= 1'b0;
      end
   end
   assign rready = ov;
   assign rdata = od;
   assign rindex = oi;
`else
   assign take = sel_ready & rrequest;
   assign rready = sel_ready;
   assign rdata = sel_data;
   assign rindex = ptr;
`endif
endmodule

// File: tb/tb_munoc_rr_gather.sv
// tb_munoc_rr_gather: queue-model self-checking bench for munoc_rr_gather (N=3, DEPTH=2, BW=8)
module tb_munoc_rr_gather;
   localparam int N = 3;
   localparam int D = 2;
`ifdef MUNOC_RR_GATHER_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif
   logic clk = 0;
   logic rstnn = 0;
   logic init = 0;
   logic [N-1:0] wready;
   logic [N-1:0] wrequest = '0;
   logic [8*N-1:0] wdata = '0;
   logic rready;
   logic rrequest = 0;
   logic [7:0] rdata;
   logic [N-1:0] rindex;
   int checks = 0;
   int errors = 0;
   logic [7:0] q [N][$];
   int ptr = 0;
   bit ov = 0;
   logic [7:0] od = 0;
   int oi = 0;
   logic [N-1:0] pu;
   bit pp;
   logic [7:0] hv;
   logic [N-1:0] ew;
   bit found;

   munoc_rr_gather #(.BW_DATA(8), .NUM_PORT(N), .DEPTH(D)) dut (
      .clk(clk), .rstnn(rstnn), .init(init), .wready(wready), .wrequest(wrequest),
      .wdata(wdata), .rready(rready), .rrequest(rrequest), .rdata(rdata), .rindex(rindex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", n, got, exp, $time);
      end
   endtask

   function automatic bit m_pop(input int i);
`ifdef MUNOC_RR_GATHER_OUTREG_EN
      return i == ptr && q[i].size() != 0 && (!ov || rrequest);
`else
      return i == ptr && q[i].size() != 0 && rrequest;
`endif
   endfunction

   function automatic bit m_wready(input int i);
      return q[i].size() < D || m_pop(i);
   endfunction

   function automatic bit m_rready();
`ifdef MUNOC_RR_GATHER_OUTREG_EN
      return ov;
`else
      return q[ptr].size() != 0;
`endif
   endfunction

   function automatic logic [7:0] m_rdata();
`ifdef MUNOC_RR_GATHER_OUTREG_EN
      return od;
`else
      return q[ptr].size() != 0 ? q[ptr][0] : 8'h00;
`endif
   endfunction

   function automatic int m_index();
`ifdef MUNOC_RR_GATHER_OUTREG_EN
      return oi;
`else
      return ptr;
`endif
   endfunction

   initial forever begin
      @(posedge clk or negedge rstnn);
      if (!rstnn) begin
         for (int i = 0; i < N; i++) q[i].delete();
         ptr = 0;
         ov = 0;
         od = 0;
         oi = 0;
      end else begin
         for (int i = 0; i < N; i++) pu[i] = wrequest[i] && m_wready(i);
         pp = m_pop(ptr);
         hv = pp ? q[ptr][0] : 8'h00;
`ifdef MUNOC_RR_GATHER_OUTREG_EN
         if (pp) begin
            ov = 1;
            od = hv;
            oi = ptr;
         end else if (ov && rrequest) ov = 0;
`endif
         if (pp) void'(q[ptr].pop_front());
         for (int i = 0; i < N; i++) if (pu[i]) q[i].push_back(wdata[8*i +: 8]);
         ptr = init ? 0 : pp ? (ptr + 1) % N : ptr;
      end
   end

   always @(negedge clk) begin
      if (!rstnn) begin
         chk("reset rready", 32'(rready), 0);
         chk("reset wready", 32'(wready), 7);
         chk("reset rindex", 32'(rindex), 1);
         chk("reset rdata", 32'(rdata), 0);
      end else begin
         for (int i = 0; i < N; i++) ew[i] = m_wready(i);
         chk("model wready", 32'(wready), 32'(ew));
         chk("model rready", 32'(rready), 32'(m_rready()));
         chk("model rindex", 32'(rindex), 32'(1) << m_index());
         if (m_rready()) chk("model rdata", 32'(rdata), 32'(m_rdata()));
      end
   end

   task automatic pull(input string n, input logic [7:0] exp);
      @(posedge clk); #1 init = 1; rrequest = 0;
      @(posedge clk); #1 init = 0; rrequest = 1;
      found = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (rready) begin
            chk(n, 32'(rdata), 32'(exp));
            found = 1;
            break;
         end
      end
      if (!found) chk({n, " timeout"}, 0, 1);
      @(posedge clk); #1 rrequest = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rstnn = 1;
      // three ports pushed together, drained in port order
      @(posedge clk); #1 wrequest = 3'b111; wdata = {8'hC0, 8'hB0, 8'hA0}; rrequest = 1;
      @(posedge clk); #1 wrequest = 0;
      repeat (LAT) begin
         @(negedge clk);
         chk("seq lat bubble", 32'(rready), 0);
      end
      @(negedge clk); chk("seq A0", 32'(rdata), 32'hA0); chk("seq idx0", 32'(rindex), 1); chk("seq rdy0", 32'(rready), 1);
      @(negedge clk); chk("seq B0", 32'(rdata), 32'hB0); chk("seq idx1", 32'(rindex), 2); chk("seq rdy1", 32'(rready), 1);
      @(negedge clk); chk("seq C0", 32'(rdata), 32'hC0); chk("seq idx2", 32'(rindex), 4); chk("seq rdy2", 32'(rready), 1);
      // an empty selected port blocks the others
      @(posedge clk); #1 wrequest = 3'b010; wdata = {8'h00, 8'h55, 8'h00};
      @(posedge clk); #1 wrequest = 0;
      repeat (4) begin
         @(negedge clk);
         chk("no skip", 32'(rready), 0);
      end
      @(posedge clk); #1 wrequest = 3'b001; wdata = {8'h00, 8'h00, 8'h11};
      @(posedge clk); #1 wrequest = 0;
      repeat (LAT) @(negedge clk);
      @(negedge clk); chk("unblock 11", 32'(rdata), 32'h11); chk("unblock rdy", 32'(rready), 1);
      @(negedge clk); chk("then 55", 32'(rdata), 32'h55); chk("then idx", 32'(rindex), 2);
      // overfill port 0
      @(posedge clk); #1 rrequest = 0; wrequest = 3'b001; wdata = 24'h000001;
      @(posedge clk); #1 wdata = 24'h000002;
      @(posedge clk); #1 wdata = 24'h000003;
      @(negedge clk); chk("full wready0", 32'(wready[0]), 0);
      @(posedge clk); #1 wrequest = 0;
      pull("drain 1st", 8'h01);
      pull("drain 2nd", 8'h02);
      @(posedge clk); #1 init = 1;
      @(posedge clk); #1 init = 0; rrequest = 1;
      repeat (4) begin
         @(negedge clk);
         chk("drain empty", 32'(rready), 0);
      end
      // init coincident with a pop from port 2
      @(posedge clk); #1 rrequest = 0; wrequest = 3'b111; wdata = {8'hC1, 8'hB1, 8'hA1};
      @(posedge clk); #1 wrequest = 3'b001; wdata = 24'h0000D1;
      @(posedge clk); #1 wrequest = 0; rrequest = 1;
      found = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (rready && rindex == 3'b100) begin
            init = 1;
            found = 1;
            break;
         end
      end
      if (!found) chk("init port2 timeout", 0, 1);
      @(posedge clk); #1 init = 0;
      found = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (rready) begin
            chk("init idx", 32'(rindex), 1);
            chk("init data", 32'(rdata), 32'hD1);
            found = 1;
            break;
         end
      end
      if (!found) chk("init next timeout", 0, 1);
      // asynchronous reset with data buffered
      @(posedge clk); #1 rrequest = 0; wrequest = 3'b111; wdata = {8'h33, 8'h22, 8'h11};
      @(posedge clk); #1 wrequest = 3'b001; wdata = 24'h000044;
      @(posedge clk); #1 wrequest = 0;
      #2 rstnn = 0;
      #1 chk("async rready", 32'(rready), 0); chk("async wready", 32'(wready), 7); chk("async rindex", 32'(rindex), 1);
      @(posedge clk); #1 rstnn = 1; rrequest = 1;
      repeat (6) begin
         @(negedge clk);
         chk("post reset empty", 32'(rready), 0);
      end
      // randomized traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1
         wrequest = N'($urandom);
         wdata = 24'($urandom);
         rrequest = ($urandom % 4) != 0;
         init = ($urandom % 16) == 0;
      end
      @(posedge clk); #1 wrequest = 0; init = 0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/munoc_rr_gather.md
MUNOC_RR_GATHER -- requirements
Module: munoc_rr_gather

Interface
REQ-001 The block SHALL have parameter BW_DATA, default 1: payload width in bits.
REQ-002 The block SHALL have parameter NUM_PORT, default 1: number of input ports (N).
REQ-003 The block SHALL have parameter DEPTH, default 1: entries per input FIFO.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-005 The block SHALL have port rstnn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port init, input, 1 bit: synchronous return of the read pointer to port 0.
REQ-007 The block SHALL have port wready, output, N bits: per-port "FIFO not full".
REQ-008 The block SHALL have port wrequest, input, N bits: per-port write strobe.
REQ-009 The block SHALL have port wdata, input, N*BW_DATA bits: port i at bits [BW_DATA*(i+1)-1 -: BW_DATA].
REQ-010 The block SHALL have port rready, output, 1 bit: merged output holds valid data.
REQ-011 The block SHALL have port rrequest, input, 1 bit: consumer pops the merged output.
REQ-012 The block SHALL have port rdata, output, BW_DATA bits: merged payload.
REQ-013 The block SHALL have port rindex, output, N bits: one-hot source port of the current rdata.

Function
REQ-014 The block SHALL merge N streams into one in strict round-robin order 0,1,...,N-1,0,...; it SHALL NOT skip an empty port.
REQ-015 Per port: a push SHALL occur when wrequest[i]&wready[i]; wrequest[i] while wready[i]=0 SHALL be ignored without data loss or corruption.
REQ-016 Per-port FIFO order SHALL be preserved; data pushed at cycle t SHALL be visible at the output no earlier than t+1.
REQ-017 A one-hot pointer SHALL select port p; rready SHALL equal "FIFO p not empty", rdata SHALL equal FIFO p head, rindex SHALL equal the pointer.
REQ-018 A pop SHALL occur when rready&rrequest: FIFO p pops, and the pointer advances to p+1, wrapping N-1 to 0.
REQ-019 rrequest while rready=0 SHALL have no effect; the pointer SHALL stay put.
REQ-020 init=1 SHALL load the pointer to port 0 at the next edge and SHALL override a same-cycle advance; a same-cycle pop SHALL still complete, and FIFO contents SHALL NOT be cleared.
REQ-021 A simultaneous push and pop on the same FIFO SHALL both complete, including when that FIFO is full with DEPTH entries.
REQ-022 N=1 SHALL degenerate to a single FIFO with rindex tied to 1.
REQ-023 Sustained throughput SHALL be one word per cycle when the selected port is non-empty.

Reset
REQ-024 While rstnn=0: all FIFOs SHALL be empty, wready SHALL be all ones, rready SHALL be 0, the pointer and rindex SHALL be one-hot port 0, and rdata SHALL be 0.
REQ-025 Reset assertion mid-transfer SHALL discard all buffered data immediately and asynchronously.

Configuration
REQ-026 The macro MUNOC_RR_GATHER_OUTREG_EN SHALL control an output register stage.
REQ-027 Without MUNOC_RR_GATHER_OUTREG_EN, rready, rdata and rindex SHALL be combinational from the FIFO head and pointer, per REQ-017.
REQ-028 With MUNOC_RR_GATHER_OUTREG_EN, a 1-entry output register SHALL be added, with the following behaviour:
- It loads from the selected FIFO when it is empty or being popped that cycle.
- rready/rdata/rindex come from the register.
- Latency grows by 1 cycle; throughput stays at 1 word per cycle.
- The register resets to empty with rdata=0.
- init does not flush it.

Structure
REQ-029 Shared package munoc_rr_gather_pkg SHALL hold the pointer-reset constant (one-hot port 0) and the port-slice width helper.
REQ-030 Each port SHALL instantiate one sub-module ervp_small_fifo (BW_DATA, DEPTH) with enable=1 and clear=0; the pointer logic SHALL be inline.

Verification
REQ-031 N=3, DEPTH=2, BW=8: push A0,B0,C0 on ports 0,1,2 at cycle 0, with rrequest held at 1 -> rdata A0,B0,C0 on cycles 1,2,3, and rindex 001,010,100.
REQ-032 N=3: only port 1 holds 0x55 and the pointer is at 0 -> rready=0 indefinitely; then push 0x11 to port 0 -> output 0x11, then 0x55.
REQ-033 DEPTH=2: three pushes to port 0 while nothing is popped -> wready[0]=0 after the 2nd push, the 3rd push is ignored, and draining yields exactly two words.
REQ-034 Pointer at port 2, init=1 in the same cycle as a pop -> the pop completes, and the next rindex is 001.
REQ-035 Assert rstnn=0 with 4 words buffered -> rready=0, wready all ones, and rindex=001 within the same cycle; no stale data appears after release.
REQ-036 With MUNOC_RR_GATHER_OUTREG_EN defined, repeat REQ-031 -> identical sequence delayed by one cycle, with no bubbles.
